// File: rtl/hog_bus_pkg.sv
// Shared definitions for the HOG bus responder: register map, CTRL/STATUS bit
// positions and FSM state codes. The optional stall timeout is HOG_BUS_TIMEOUT_EN.
package hog_bus_pkg;

  localparam int unsigned REG_CTRL      = 0;
  localparam int unsigned REG_STATUS    = 1;
  localparam int unsigned REG_IRQ_CLR   = 2;
  localparam int unsigned REG_PIX_TX    = 3;
  localparam int unsigned REG_RES_RX    = 4;
  localparam int unsigned SCRATCH_BASE  = 8;
  localparam int unsigned SCRATCH_WORDS = 8;
  localparam int unsigned SCRATCH_IDX_W = 3;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_IRQ_EN   = 1;
  localparam int unsigned CTRL_DROP_PIX = 2;

  localparam int unsigned STAT_BUSY        = 0;
  localparam int unsigned STAT_IRQ_PENDING = 1;
  localparam int unsigned STAT_PIX_VALID   = 2;
  localparam int unsigned STAT_RES_VALID   = 3;
  localparam int unsigned STAT_TIMEOUT_ERR = 4;
  localparam int unsigned STAT_PIX_CNT_LSB = 32;
  localparam int unsigned STAT_RES_CNT_LSB = 64;

  localparam int unsigned CNT_W = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_DECODE   = 3'd1;
  localparam state_t ST_PIX_WAIT = 3'd2;
  localparam state_t ST_RES_WAIT = 3'd3;
  localparam state_t ST_ACK      = 3'd4;
  localparam state_t ST_HOLD     = 3'd5;

endpackage

// File: rtl/hog_bus_regfile.sv
// Scratch register array: 8 bus-wide words, byte-enabled write, registered read.
module hog_bus_regfile
  import hog_bus_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 128,
  parameter int unsigned BUS_BYTES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [SCRATCH_IDX_W-1:0] wr_idx,
  input  logic [BUS_WIDTH-1:0]     wr_data,
  input  logic [BUS_BYTES-1:0]     wr_be,
  input  logic                     rd_en,
  input  logic [SCRATCH_IDX_W-1:0] rd_idx,
  output logic [BUS_WIDTH-1:0]     rd_data
);

  logic [BUS_WIDTH-1:0] mem [SCRATCH_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SCRATCH_WORDS); i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        for (int b = 0; b < int'(BUS_BYTES); b++) begin
          if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
      if (rd_en) rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/hog_bus_responder.sv
// Bus responder for the HOG core: register access, pixel push stream, result pop stream.
// Define HOG_BUS_TIMEOUT_EN to bound stream waits by TIMEOUT_CYCLES.
module hog_bus_responder
  import hog_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned BUS_WIDTH      = 128,
  parameter int unsigned BUS_BYTES      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  bus_enable,
  input  logic                  r_wbar,
  input  logic [BUS_WIDTH-1:0]  write_data,
  input  logic [BUS_BYTES-1:0]  byte_enable,
  output logic                  ack,
  output logic [BUS_WIDTH-1:0]  read_data,
  output logic                  irq,
  output logic                  start,
  input  logic                  busy,
  input  logic                  done,
  output logic [BUS_WIDTH-1:0]  pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  input  logic [BUS_WIDTH-1:0]  res_data,
  input  logic                  res_valid,
  output logic                  res_ready
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rd_q;
  logic [BUS_WIDTH-1:0]  wdata_q;
  logic [BUS_BYTES-1:0]  be_q;

  logic                  irq_en, irq_pending, timeout_err;
  logic [CNT_W-1:0]      pix_count, res_count;
  logic [BUS_WIDTH-1:0]  rf_rdata, reg_rdata_c, pix_word_c;

  logic sel_ctrl_c, sel_status_c, sel_irq_clr_c, sel_pix_c, sel_res_c, sel_scratch_c;
  logic accept_c, reg_wr_c, reg_rd_c, pix_load_c, pix_fire_c, res_fire_c;
  logic pix_tmo_c, res_tmo_c, stall_hit_c;
  logic ctrl_wr_c, irq_clr_c, drop_pix_c, irq_en_d, irq_pending_d;

  assign sel_ctrl_c    = (32'(addr_q) == REG_CTRL);
  assign sel_status_c  = (32'(addr_q) == REG_STATUS);
  assign sel_irq_clr_c = (32'(addr_q) == REG_IRQ_CLR);
  assign sel_pix_c     = (32'(addr_q) == REG_PIX_TX);
  assign sel_res_c     = (32'(addr_q) == REG_RES_RX);
  assign sel_scratch_c = (32'(addr_q) >= SCRATCH_BASE) &&
                         (32'(addr_q) <  SCRATCH_BASE + SCRATCH_WORDS);

  // Stall counter is only present when stream waits are bounded.
`ifdef HOG_BUS_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state_q == ST_PIX_WAIT || state_q == ST_RES_WAIT) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end else begin
      stall_cnt <= '0;
    end
  end

  assign stall_hit_c = (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));
`else
  logic timeout_cfg_unused;
  assign timeout_cfg_unused = (TIMEOUT_CYCLES != 0);
  assign stall_hit_c        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    reg_wr_c   = 1'b0;
    reg_rd_c   = 1'b0;
    pix_load_c = 1'b0;
    pix_fire_c = 1'b0;
    res_fire_c = 1'b0;
    pix_tmo_c  = 1'b0;
    res_tmo_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_enable) begin
          accept_c = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!rd_q && sel_pix_c) begin
          pix_load_c = 1'b1;
          state_d    = ST_PIX_WAIT;
        end else if (rd_q && sel_res_c) begin
          state_d = ST_RES_WAIT;
        end else begin
          reg_wr_c = !rd_q;
          reg_rd_c = rd_q;
          state_d  = ST_ACK;
        end
      end
      ST_PIX_WAIT: begin
        if (pix_valid && pix_ready) begin
          pix_fire_c = 1'b1;
          state_d    = ST_ACK;
        end else if (stall_hit_c) begin
          pix_tmo_c = 1'b1;
          state_d   = ST_ACK;
        end
      end
      ST_RES_WAIT: begin
        if (res_valid) begin
          res_fire_c = 1'b1;
          state_d    = ST_ACK;
        end else if (stall_hit_c) begin
          res_tmo_c = 1'b1;
          state_d   = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Disabled bytes of a pixel word go out as zero.
  always_comb begin
    pix_word_c = '0;
    for (int b = 0; b < int'(BUS_BYTES); b++) begin
      if (be_q[b]) pix_word_c[b*8 +: 8] = wdata_q[b*8 +: 8];
    end
  end

  always_comb begin
    reg_rdata_c = '0;
    if (sel_ctrl_c) begin
      reg_rdata_c[CTRL_IRQ_EN] = irq_en;
    end else if (sel_status_c) begin
      reg_rdata_c[STAT_BUSY]                  = busy;
      reg_rdata_c[STAT_IRQ_PENDING]           = irq_pending;
      reg_rdata_c[STAT_PIX_VALID]             = pix_valid;
      reg_rdata_c[STAT_RES_VALID]             = res_valid;
      reg_rdata_c[STAT_TIMEOUT_ERR]           = timeout_err;
      reg_rdata_c[STAT_PIX_CNT_LSB +: CNT_W]  = pix_count;
      reg_rdata_c[STAT_RES_CNT_LSB +: CNT_W]  = res_count;
    end else if (sel_scratch_c) begin
      reg_rdata_c = rf_rdata;
    end
  end

  // A done pulse outranks a simultaneous clear.
  assign ctrl_wr_c     = reg_wr_c && sel_ctrl_c && be_q[0];
  assign irq_clr_c     = reg_wr_c && sel_irq_clr_c && wdata_q[0];
  assign drop_pix_c    = ctrl_wr_c && wdata_q[CTRL_DROP_PIX];
  assign irq_en_d      = ctrl_wr_c ? wdata_q[CTRL_IRQ_EN] : irq_en;
  assign irq_pending_d = done ? 1'b1 : (irq_clr_c ? 1'b0 : irq_pending);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      ack         <= 1'b0;
      read_data   <= '0;
      irq         <= 1'b0;
      irq_en      <= 1'b0;
      irq_pending <= 1'b0;
      timeout_err <= 1'b0;
      start       <= 1'b0;
      pix_data    <= '0;
      pix_valid   <= 1'b0;
      res_ready   <= 1'b0;
      pix_count   <= '0;
      res_count   <= '0;
    end else begin
      if (accept_c) begin
        addr_q  <= addr;
        rd_q    <= r_wbar;
        wdata_q <= write_data;
        be_q    <= byte_enable;
      end
      ack         <= (state_d == ST_ACK);
      start       <= ctrl_wr_c && wdata_q[CTRL_START];
      res_ready   <= res_fire_c;
      irq_en      <= irq_en_d;
      irq_pending <= irq_pending_d;
      irq         <= irq_pending_d && irq_en_d;

      if (pix_tmo_c || res_tmo_c) timeout_err <= 1'b1;
      else if (irq_clr_c)         timeout_err <= 1'b0;

      if (pix_load_c) begin
        pix_data  <= pix_word_c;
        pix_valid <= 1'b1;
      end else if (pix_fire_c) begin
        pix_valid <= 1'b0;
        pix_count <= pix_count + CNT_W'(1);
      end else if (pix_tmo_c || drop_pix_c) begin
        pix_valid <= 1'b0;
      end

      if (reg_rd_c) begin
        read_data <= reg_rdata_c;
      end else if (res_fire_c) begin
        read_data <= res_data;
        res_count <= res_count + CNT_W'(1);
      end else if (res_tmo_c) begin
        read_data <= '0;
      end
    end
  end

  hog_bus_regfile #(
    .BUS_WIDTH (BUS_WIDTH),
    .BUS_BYTES (BUS_BYTES)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (reg_wr_c && sel_scratch_c),
    .wr_idx  (addr_q[SCRATCH_IDX_W-1:0]),
    .wr_data (wdata_q),
    .wr_be   (be_q),
    .rd_en   (accept_c),
    .rd_idx  (addr[SCRATCH_IDX_W-1:0]),
    .rd_data (rf_rdata)
  );

endmodule

// File: tb/tb_hog_bus_responder.sv
// Scoreboard bench for hog_bus_responder: directed scenarios plus random bus traffic
// against a register-level model; build with HOG_BUS_TIMEOUT_EN to add the timeout case.
module tb_hog_bus_responder;

  localparam int unsigned AW  = 5;
  localparam int unsigned BW  = 128;
  localparam int unsigned BB  = 16;
  localparam int          TMO = 16;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic          bus_enable, r_wbar, busy, done, pix_ready, res_valid;
  logic [BW-1:0] write_data, res_data;
  logic [BB-1:0] byte_enable;
  logic          ack, irq, start, pix_valid, res_ready;
  logic [BW-1:0] read_data, pix_data;

  hog_bus_responder #(
    .ADDR_WIDTH(AW), .BUS_WIDTH(BW), .BUS_BYTES(BB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .bus_enable(bus_enable), .r_wbar(r_wbar),
    .write_data(write_data), .byte_enable(byte_enable), .ack(ack), .read_data(read_data),
    .irq(irq), .start(start), .busy(busy), .done(done), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] data;
    logic          start;
  } exp_t;

  exp_t          exp_q[$];
  logic [BW-1:0] pix_q[$];
  int            checks = 0;
  int            failures = 0;
  int            res_ready_cnt = 0;

  // Reference model: register contents and counters as the bus should see them.
  logic [BW-1:0] m_scr [8];
  logic          m_irq_en, m_pend, m_terr;
  logic [15:0]   m_pix_cnt, m_res_cnt;
  logic [BW-1:0] m_last;

  task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_scr[i] = '0;
    m_irq_en = 0; m_pend = 0; m_terr = 0;
    m_pix_cnt = 0; m_res_cnt = 0; m_last = '0;
    exp_q.delete();
    pix_q.delete();
  endtask

  function automatic logic [BW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: pops the scoreboard on every ack and every pixel handshake.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (pix_valid && pix_ready) begin
        if (pix_q.size() == 0) fail_now("pix_unexpected");
        else check("pix_data", pix_data, pix_q.pop_front());
      end
      if (res_ready) res_ready_cnt++;
      if (ack) begin
        if (exp_q.size() == 0) begin
          fail_now("ack_unexpected");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("read_data", read_data, e.data);
          check("start_with_ack", BW'(start), BW'(e.start));
        end
      end else if (start) begin
        fail_now("start_without_ack");
      end
    end
  end

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // One bus access. stall: cycles of pix_ready/res_valid delay, -1 = never respond.
  task automatic bus_op(input int a, input bit rd, input logic [BW-1:0] wd,
                        input logic [BB-1:0] be, input int stall, input bit done_dec,
                        input logic [BW-1:0] rdat, input logic bsy);
    exp_t          e;
    int            exp_lat, cyc, rr0;
    bit            got, vbad, is_pix, is_res;
    logic [BW-1:0] v, pw;
    e.start = 1'b0;
    exp_lat = 2;
    is_pix  = !rd && a == 3;
    is_res  = rd && a == 4;
    if (rd) begin
      v = '0;
      if (a == 0) v[1] = m_irq_en;
      else if (a == 1) begin
        v[0] = bsy; v[1] = m_pend; v[4] = m_terr;
        v[47:32] = m_pix_cnt; v[79:64] = m_res_cnt;
      end else if (a == 4) begin
        if (stall < 0) begin exp_lat = 2 + TMO; m_terr = 1; end
        else begin exp_lat = 3 + stall; v = rdat; m_res_cnt++; end
      end else if (a >= 8 && a < 16) v = m_scr[a-8];
      m_last = v;
    end else begin
      if (a == 0 && be[0]) begin
        m_irq_en = wd[1];
        e.start  = wd[0];
      end else if (a == 2 && wd[0]) begin
        m_pend = 0; m_terr = 0;
      end else if (a == 3) begin
        pw = '0;
        for (int b = 0; b < int'(BB); b++) if (be[b]) pw[b*8 +: 8] = wd[b*8 +: 8];
        if (stall < 0) begin exp_lat = 2 + TMO; m_terr = 1; end
        else begin exp_lat = 3 + stall; pix_q.push_back(pw); m_pix_cnt++; end
      end else if (a >= 8 && a < 16) begin
        for (int b = 0; b < int'(BB); b++) if (be[b]) m_scr[a-8][b*8 +: 8] = wd[b*8 +: 8];
      end
    end
    if (done_dec) m_pend = 1;
    e.data = m_last;
    exp_q.push_back(e);

    @(negedge clk);
    busy = bsy; addr = AW'(a); r_wbar = rd; write_data = wd; byte_enable = be;
    bus_enable = 1'b1;
    rr0 = res_ready_cnt; vbad = 0; cyc = 0; got = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      done = done_dec && cyc == 1;
      if (is_res) begin
        res_data  = rdat;
        res_valid = stall >= 0 && cyc >= 2 + stall;
      end
      if (is_pix) pix_ready = stall >= 0 && cyc >= 2 + stall;
      got = ack;
      if (is_pix && cyc >= 2 && !ack && !pix_valid) vbad = 1;
    end
    if (!got) begin
      fail_now("ack_timeout");
      finish_run();
    end
    check("ack_latency", BW'(cyc), BW'(exp_lat));
    @(negedge clk);
    bus_enable = 0; pix_ready = 0; res_valid = 0; done = 0;
    @(negedge clk);
    if (is_res) check("res_ready_pulses", BW'(res_ready_cnt - rr0), BW'(stall >= 0 ? 1 : 0));
    if (is_pix) check("pix_valid_held", BW'(vbad), '0);
    check("irq_level", BW'(irq), BW'(m_pend & m_irq_en));
  endtask

  task automatic pulse_done();
    @(negedge clk);
    done = 1'b1;
    m_pend = 1;
    @(negedge clk);
    done = 1'b0;
    check("irq_after_done", BW'(irq), BW'(m_irq_en));
  endtask

  initial begin
    logic [BW-1:0] w;
    int            k, a, sel;
    bit            rd;
    rst_n = 0; addr = '0; bus_enable = 0; r_wbar = 0; write_data = '0; byte_enable = '0;
    busy = 0; done = 0; pix_ready = 0; res_valid = 0; res_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_outputs", BW'({ack, irq, start, pix_valid, res_ready}), '0);
    check("rst_read_data", read_data, '0);
    check("rst_pix_data", pix_data, '0);
    rst_n = 1;

    bus_op(1, 1, '0, '0, 0, 0, '0, 1'b1);
    w = {16{8'hAA}};
    bus_op(9, 0, w, 16'h000F, 0, 0, '0, 1'b0);
    bus_op(9, 1, '0, '0, 0, 0, '0, 1'b0);
    bus_op(3, 0, 128'h0123456789ABCDEF0123456789ABCDEF, '1, 10, 0, '0, 1'b0);
    bus_op(1, 1, '0, '0, 0, 0, '0, 1'b0);
    bus_op(4, 1, '0, '0, 5, 0, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 1'b0);
    bus_op(0, 0, 128'h2, '1, 0, 0, '0, 1'b0);
    pulse_done();
    bus_op(2, 0, 128'h1, '1, 0, 1, '0, 1'b0);
    bus_op(2, 0, 128'h1, '1, 0, 0, '0, 1'b0);
`ifdef HOG_BUS_TIMEOUT_EN
    bus_op(4, 1, '0, '0, -1, 0, '0, 1'b0);
    bus_op(1, 1, '0, '0, 0, 0, '0, 1'b0);
    bus_op(3, 0, rand_word(), '1, -1, 0, '0, 1'b0);
    bus_op(2, 0, 128'h1, '1, 0, 0, '0, 1'b0);
`endif

    for (int i = 0; i < 160; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: bus_op(8 + int'($urandom_range(0, 7)), 0, rand_word(), BB'($urandom), 0, 0, '0, 1'b0);
        1: bus_op(8 + int'($urandom_range(0, 7)), 1, '0, '0, 0, 0, '0, 1'b0);
        2: bus_op(1, 1, '0, '0, 0, 0, '0, 1'($urandom));
        3: bus_op(0, 0, rand_word(), BB'($urandom), 0, 0, '0, 1'b0);
        4: bus_op(0, 1, '0, '0, 0, 0, '0, 1'b0);
        5: bus_op(2, 0, rand_word(), '1, 0, 1'($urandom), '0, 1'b0);
        6: bus_op(3, 0, rand_word(), BB'($urandom), int'($urandom_range(0, 4)), 0, '0, 1'b0);
        7: bus_op(4, 1, '0, '0, int'($urandom_range(0, 4)), 0, rand_word(), 1'b0);
        8: pulse_done();
        default: begin
          k  = int'($urandom_range(0, 20));
          rd = 1'($urandom);
          if (k == 0)      begin a = 3; rd = 1; end
          else if (k == 1) begin a = 4; rd = 0; end
          else if (k < 5)  a = k + 3;
          else             a = k + 11;
          bus_op(a, rd, rand_word(), '1, 0, 0, '0, 1'b0);
        end
      endcase
    end

    // Reset in the middle of a stalled pixel push.
    @(negedge clk);
    addr = AW'(3); r_wbar = 0; write_data = rand_word(); byte_enable = '1; bus_enable = 1;
    repeat (5) @(negedge clk);
    check("pix_valid_stalled", BW'(pix_valid), BW'(1));
    rst_n = 0;
    #1;
    check("pix_valid_abort", BW'({pix_valid, ack}), '0);
    bus_enable = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    bus_op(1, 1, '0, '0, 0, 0, '0, 1'b0);
    bus_op(12, 1, '0, '0, 0, 0, '0, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", BW'(exp_q.size() + pix_q.size()), '0);
    finish_run();
  end

endmodule

// File: doc/hog_bus_responder.md
Name: hog_bus_responder

Overview:
- Responder (slave) end of the HPS external-bus bridge.
- Serves the initiator signals: addr, bus_enable, r_wbar, write_data and byte_enable.
- Returns a one-cycle ack pulse, read_data and a level irq.
- Bus side: exposes control/status/scratch registers to the HPS.
- Core side: converts writes into a 128-bit pixel stream (valid/ready) toward the HOG core, and converts reads into pops from the core's result stream.

Parameters:
- ADDR_WIDTH, 5: word address width; one address = one BUS_WIDTH word.
- BUS_WIDTH, 128: data bus width in bits.
- BUS_BYTES, 16: BUS_WIDTH/8, the byte_enable width.
- TIMEOUT_CYCLES, 1024: stream stall limit. Used only with HOG_BUS_TIMEOUT_EN.

Ports:
- clk  in  1  single clock for both the bus and the core side.
- rst_n  in  1  asynchronous, active-low reset.
- addr  in  ADDR_WIDTH  word address.
- bus_enable  in  1  request; held by the initiator until ack.
- r_wbar  in  1  1 = read, 0 = write.
- write_data  in  BUS_WIDTH  write payload.
- byte_enable  in  BUS_BYTES  per-byte write strobes.
- ack  out  1  one-cycle completion pulse.
- read_data  out  BUS_WIDTH  valid while ack is high.
- irq  out  1  level interrupt.
- start  out  1  one-cycle pulse to the core.
- busy  in  1  core busy.
- done  in  1  core completion pulse.
- pix_data  out  BUS_WIDTH  pixel word to the core.
- pix_valid  out  1  pixel word valid.
- pix_ready  in  1  core accepts the pixel word.
- res_data  in  BUS_WIDTH  result word from the core.
- res_valid  in  1  result word valid.
- res_ready  out  1  pop strobe to the core.

Behaviour:
- Reset: all outputs are 0, all registers are 0, and the FSM is in IDLE.
- Address map (word addresses):
  - 0 CTRL: bit0 start (write-1 pulses start, reads 0); bit1 irq_en; bit2 drop_pix (write-1 discards a pending pix word).
  - 1 STATUS (read-only): bit0 busy; bit1 irq_pending; bit2 pix_valid; bit3 res_valid; bit4 timeout_err; [47:32] pix_count; [79:64] res_count.
  - 2 IRQ_CLR: write with bit0 = 1 clears irq_pending; also clears timeout_err.
  - 3 PIX_TX: write only.
  - 4 RES_RX: read only.
  - 8–15 SCRATCH: read/write, byte-enabled.
  - All other addresses, and reads of write-only locations: read 0, writes ignored, normal ack latency.
- Byte enables apply to CTRL and SCRATCH. For PIX_TX, disabled bytes are driven as 0 in pix_data.
- FSM states: IDLE, DECODE, PIX_WAIT, RES_WAIT, ACK, HOLD.
- IDLE: bus_enable sampled high at edge N moves to DECODE and latches addr, r_wbar, data and byte_enable.
- DECODE, register access: the write is performed or read_data is registered, then ACK. ack is high during cycle N+2, i.e. 2-cycle latency.
- DECODE, PIX_TX write: pix_data is loaded, pix_valid = 1, go to PIX_WAIT.
- PIX_WAIT: hold until pix_valid && pix_ready. Then clear pix_valid, increment pix_count and go to ACK.
- DECODE, RES_RX read: go to RES_WAIT.
- RES_WAIT: when res_valid is high, res_ready pulses for one cycle, read_data is captured from res_data, res_count increments, and the FSM goes to ACK.
- ACK: ack = 1 for exactly one cycle. Then HOLD.
- HOLD: ignores bus_enable for one cycle, so a stale request is never double-served. Then IDLE.
- read_data holds its value until the next read completes.
- Counters are 16-bit and wrap from 0xFFFF to 0.
- irq_pending is set by the done pulse.
- Simultaneous done and IRQ_CLR: set wins, so irq_pending stays 1.
- irq = irq_pending & irq_en, registered, so it rises one cycle after the cause.
- start pulses one cycle after the CTRL write is in DECODE. It is issued regardless of busy.
- Asserting rst_n low mid-transaction aborts it: no ack, pix_valid drops, the FSM returns to IDLE.
- Without the optional feature, a stalled stream access never acks. This is intended backpressure.

Optional Feature:
- Macro: HOG_BUS_TIMEOUT_EN.
- Enabled: a stall counter runs in PIX_WAIT and RES_WAIT. When it reaches TIMEOUT_CYCLES, the FSM goes to ACK.
  - PIX_WAIT timeout: the pix word is dropped and pix_valid cleared.
  - RES_WAIT timeout: read_data = 0 and res_ready is not pulsed.
  - Either timeout sets timeout_err; pix_count/res_count are not incremented.
- Disabled: no counter, timeout_err reads 0, and stream waits are unbounded.

Decomposition:
- Shared package hog_bus_pkg holds:
  - the register address localparams (CTRL, STATUS, IRQ_CLR, PIX_TX, RES_RX, SCRATCH_BASE);
  - CTRL and STATUS bit-index constants;
  - the FSM state enum.
- One sub-module, hog_bus_regfile: the 8×BUS_WIDTH scratch array with byte-enable write and registered read.

Test Plan:
- Reset release, then a read of STATUS at addr 1 with busy = 1 → ack at cycle +2; read_data = 0x…0001; irq = 0.
- Write SCRATCH addr 9 with data 0xAA…AA and byte_enable 0x000F, then read it back → only bytes [3:0] = 0xAA; the rest 0; one ack per access.
- PIX_TX write 0x0123…CDEF with pix_ready held low for 10 cycles → pix_valid high throughout and no ack; after pix_ready rises → ack 1 cycle later, pix_count = 1.
- RES_RX read with res_valid rising after 5 cycles, res_data = 0xDEAD…BEEF → single res_ready pulse; ack with read_data = 0xDEAD…BEEF.
- CTRL write 0x2, then a done pulse → irq high next cycle; IRQ_CLR write issued in the same cycle as a second done pulse → irq stays 1; a later IRQ_CLR → irq 0.
- HOG_BUS_TIMEOUT_EN with TIMEOUT_CYCLES = 16 and RES_RX read while res_valid = 0 → ack after the timeout, read_data = 0, STATUS bit4 = 1, res_count unchanged.
